// File: rtl/mux_nto1_pipe.sv
// N-channel valid/ready selector with a single registered output stage.
// Optional round-robin arbitration is built when MUX_RR_EN is defined; otherwise it is direct sel only.
module mux_nto1_lane #(
  parameter int IDX  = 0,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] i_g,
  input  logic            i_en,
  output logic            o_ready
);
  assign o_ready = i_en && (i_g == SELW'(IDX));
endmodule

module mux_nto1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N*WIDTH-1:0] inData,
  input  logic [N-1:0]       inValid,
  output logic [N-1:0]       inReady,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out,
  output logic [SELW-1:0]    outSel,
  output logic               outValid,
  input  logic               outReady
);
  logic [WIDTH-1:0] r_out;
  logic [SELW-1:0]  r_sel;
  logic             r_vld;
  logic             w_can_accept;
  logic             w_dir_gnt;
  logic             w_gnt;
  logic [SELW-1:0]  w_g;
  logic             w_en;

  assign w_can_accept = !r_vld || outReady;

  // Out-of-range sel (only possible when N < 2**SELW) never grants.
  always_comb begin
    w_dir_gnt = 1'b0;
    if (int'(sel) < N) w_dir_gnt = inValid[sel];
  end

`ifdef MUX_RR_EN
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_rr_g;
  logic            w_rr_gnt;
  int              w_idx;

  // First valid channel at or after the pointer, wrapping at N.
  always_comb begin
    w_rr_gnt = 1'b0;
    w_rr_g   = '0;
    w_idx    = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_rr_gnt && inValid[w_idx]) begin
        w_rr_gnt = 1'b1;
        w_rr_g   = SELW'(w_idx);
      end
    end
  end

  assign w_gnt = mode ? w_rr_gnt : w_dir_gnt;
  assign w_g   = mode ? w_rr_g   : sel;

  always_ff @(posedge Clk) begin
    if (Rst)
      r_ptr <= '0;
    else if (w_en && mode)
      r_ptr <= (w_g == SELW'(N-1)) ? '0 : w_g + 1'b1;
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_gnt = w_dir_gnt;
  assign w_g   = sel;
`endif

  assign w_en = w_gnt && w_can_accept && !Rst;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mux_nto1_lane #(.IDX(gi), .SELW(SELW)) u_lane (
      .i_g     (w_g),
      .i_en    (w_en),
      .o_ready (inReady[gi])
    );
  end

  // A capture on the same edge as a pop simply overwrites the held word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out <= '0;
      r_sel <= '0;
      r_vld <= 1'b0;
    end else if (w_en) begin
      r_out <= inData[int'(w_g)*WIDTH +: WIDTH];
      r_sel <= w_g;
      r_vld <= 1'b1;
    end else if (outReady) begin
      r_vld <= 1'b0;
    end
  end

  assign out      = r_out;
  assign outSel   = r_sel;
  assign outValid = r_vld;
endmodule
